// File: rtl/key_debounce.sv
// Key input stage: two-flop synchroniser plus an independent stability-counter debouncer per
// key. Produces clean active-low levels, one-cycle press/release strobes, an any-pressed flag
// and the 1-based index of the lowest pressed key.
module key_debounce #(
    parameter int unsigned KEY_W      = 6,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_out,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic             key_any,
    output logic [2:0]       key_code
);

    // key_code is 3 bits wide, so at most seven keys can be encoded.
    if (KEY_W > 7) begin : g_bad_key_w
        $fatal(1, "key_debounce: KEY_W must be 7 or less");
    end

    if ((DEB_CYCLES < 2) || (64'(DEB_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_deb
        $fatal(1, "key_debounce: DEB_CYCLES must be in 2..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

    logic [KEY_W-1:0] sync1_q, sync2_q;
    logic [KEY_W-1:0] out_q, out_d;
    logic [KEY_W-1:0] press_q, press_d;
    logic [KEY_W-1:0] release_q, release_d;
    logic [CNT_W-1:0] cnt_q [KEY_W];
    logic [CNT_W-1:0] cnt_d [KEY_W];
    logic             any_q, any_d;
    logic [2:0]       code_q, code_d;

    // Two-stage synchroniser; resets to released so no spurious press leaves reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    // Per-key stability counting, level acceptance and strobe generation.
    always_comb begin
        out_d     = out_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < KEY_W; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != out_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    out_d[i]     = sync2_q[i];
                    press_d[i]   = ~sync2_q[i];
                    release_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Summary flags are derived from next-state levels so they line up with key_out.
    always_comb begin
        any_d  = ~&out_d;
        code_d = 3'd0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (!out_d[i]) begin
                code_d = 3'(i + 1);
            end
        end
    end

    // Debouncer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '1;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
            code_q    <= 3'd0;
            for (int i = 0; i < KEY_W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
            code_q    <= code_d;
            for (int i = 0; i < KEY_W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key_out     = out_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_any     = any_q;
    assign key_code    = code_q;

endmodule
